// File: rtl/cory_demuxn_pkg.sv
// cory_demuxn_pkg: shared constants and helpers for the cory_demuxn slice.
//   CORY_DEMUX_IDX   - MODE value for binary index select
//   CORY_DEMUX_BCAST - MODE value for one-hot/multi-hot broadcast mask
//   sel_width()      - select width for a given output count and mode
package cory_demuxn_pkg;

  localparam int CORY_DEMUX_IDX   = 0;
  localparam int CORY_DEMUX_BCAST = 1;

  // Broadcast carries one mask bit per output; index mode needs
  // max(1, clog2(m)) bits.
  function automatic int sel_width(input int m, input int mode);
    if (mode == CORY_DEMUX_BCAST) return m;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cory_demuxn_if.sv
// cory_demuxn_if: bundle of the demux streams.
//   i_s_v/i_s_d/o_s_r : select stream (SW bits)
//   i_a_v/i_a_d/o_a_r : data stream (N bits)
//   o_z_v/o_z_d/i_z_r : M output streams, lane k at o_z_d[k*N +: N]
//   o_err             : one-cycle pulse after an invalid select is dropped
// master = environment (drives sources and output ready), slave = demux.
interface cory_demuxn_if #(
  parameter int N  = 8,
  parameter int M  = 4,
  parameter int SW = 2
);
  logic            i_s_v;
  logic [SW-1:0]   i_s_d;
  logic            o_s_r;
  logic            i_a_v;
  logic [N-1:0]    i_a_d;
  logic            o_a_r;
  logic [M-1:0]    o_z_v;
  logic [M*N-1:0]  o_z_d;
  logic [M-1:0]    i_z_r;
  logic            o_err;

  modport master (
    output i_s_v, i_s_d, i_a_v, i_a_d, i_z_r,
    input  o_s_r, o_a_r, o_z_v, o_z_d, o_err
  );

  modport slave (
    input  i_s_v, i_s_d, i_a_v, i_a_d, i_z_r,
    output o_s_r, o_a_r, o_z_v, o_z_d, o_err
  );
endinterface

// File: rtl/cory_demuxn_queue.sv
// cory_demuxn_queue: per-lane output buffer (cory_queue semantics).
//   Q = 0 : combinational pass-through (o_r follows i_r).
//   Q >= 1: FIFO of depth Q; o_r depends only on the full state, so a
//           word written this cycle appears at the output next cycle.
// Ports: clk, reset_n (async low), i_v/i_d/o_r (write side),
//        o_v/o_d/i_r (read side).
module cory_demuxn_queue #(
  parameter int N = 8,
  parameter int Q = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_v,
  input  logic [N-1:0] i_d,
  output logic         o_r,
  output logic         o_v,
  output logic [N-1:0] o_d,
  input  logic         i_r
);

  if (Q == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk ^ reset_n;
    assign o_v = i_v;
    assign o_d = i_d;
    assign o_r = i_r;
  end else begin : g_fifo
    localparam int PW = (Q < 2) ? 1 : $clog2(Q);
    localparam int CW = $clog2(Q + 1);

    // Storage is rounded up to a power of two so every pointer value
    // indexes a real entry; pointers still wrap at Q-1.
    logic [N-1:0]  mem [2**PW];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          push, pop;

    assign o_r  = (cnt != CW'(Q));
    assign o_v  = (cnt != '0);
    assign o_d  = mem[rp];
    assign push = i_v && o_r;
    assign pop  = o_v && i_r;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= (wp == PW'(Q - 1)) ? '0 : wp + PW'(1);
        if (pop)  rp <= (rp == PW'(Q - 1)) ? '0 : rp + PW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wp] <= i_d;
    end
  end

endmodule

// File: rtl/cory_demuxn.sv
// cory_demuxn: M-way demultiplexer with per-lane buffering.
//   MODE = CORY_DEMUX_IDX  : i_s_d is a binary lane index (>= M is invalid)
//   MODE = CORY_DEMUX_BCAST: i_s_d is a lane mask (0 is invalid)
// Select and data are consumed together (o_s_r == o_a_r). A broadcast that
// only partially lands is remembered in 'sent' so delivered lanes are not
// written twice while the rest stall. Invalid selects are consumed at once
// and reported by o_err on the following cycle.
// Ports: clk, reset_n (async low), bus (cory_demuxn_if.slave).
module cory_demuxn
  import cory_demuxn_pkg::*;
#(
  parameter int N    = 8,
  parameter int M    = 4,
  parameter int Q    = 0,
  parameter int MODE = CORY_DEMUX_IDX
) (
  input logic          clk,
  input logic          reset_n,
  cory_demuxn_if.slave bus
);

  localparam int SW = sel_width(M, MODE);

  logic [SW-1:0]       sel;
  logic [M-1:0]        tgt, lv, lr, acc, sent, zv;
  logic [M-1:0][N-1:0] zd;
  logic                txn, done, err_q;

  assign sel = bus.i_s_d;
  assign txn = bus.i_a_v && bus.i_s_v;

  if (MODE == CORY_DEMUX_BCAST) begin : g_bcast
    assign tgt = sel;
  end else begin : g_idx
    assign tgt = (int'(sel) < M) ? (M'(1) << sel) : '0;
  end

  assign lv  = {M{txn}} & tgt & ~sent;
  assign acc = lv & lr;
  // An empty target set is trivially done, which drops invalid selects.
  assign done = txn && (((sent | acc) & tgt) == tgt);

  assign bus.o_a_r = done;
  assign bus.o_s_r = done;
  assign bus.o_err = err_q;
  assign bus.o_z_v = zv;
  assign bus.o_z_d = zd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sent  <= '0;
      err_q <= 1'b0;
    end else begin
      if (MODE == CORY_DEMUX_BCAST) sent <= done ? '0 : (sent | acc);
      err_q <= txn && (tgt == '0);
    end
  end

  for (genvar k = 0; k < M; k++) begin : g_lane
    cory_demuxn_queue #(.N(N), .Q(Q)) u_q (
      .clk     (clk),
      .reset_n (reset_n),
      .i_v     (lv[k]),
      .i_d     (tgt[k] ? bus.i_a_d : '0),
      .o_r     (lr[k]),
      .o_v     (zv[k]),
      .o_d     (zd[k]),
      .i_r     (bus.i_z_r[k])
    );
  end

`ifdef SIM
  // While some lanes are already delivered, the source must keep its mask.
  logic [SW-1:0] sel_q;
  always_ff @(posedge clk) begin
    if ((|sent) && txn && (sel != sel_q)) begin
      $display("ERROR: cory_demuxn select changed mid-broadcast");
      $finish;
    end
    sel_q <= sel;
  end
`endif

endmodule

// File: tb/tb_cory_demuxn.sv
// tb_cory_demuxn: directed checks on an index demux (M=3, Q=1) and a
// broadcast demux (M=4, Q=0), then random traffic on a broadcast demux
// (M=8, Q=4) against a per-lane expected-word queue.
module tb_cory_demuxn;
  import cory_demuxn_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cnt1 [4];
  logic [7:0] expq [8][$];

  cory_demuxn_if #(.N(8), .M(3), .SW(2)) b0 ();
  cory_demuxn_if #(.N(8), .M(4), .SW(4)) b1 ();
  cory_demuxn_if #(.N(8), .M(8), .SW(8)) b2 ();

  cory_demuxn #(.N(8), .M(3), .Q(1), .MODE(CORY_DEMUX_IDX)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(b0));
  cory_demuxn #(.N(8), .M(4), .Q(0), .MODE(CORY_DEMUX_BCAST)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1));
  cory_demuxn #(.N(8), .M(8), .Q(4), .MODE(CORY_DEMUX_BCAST)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(b2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [2:0] r);
    @(posedge clk); #1;
    b0.i_a_v = v; b0.i_s_v = v; b0.i_s_d = s; b0.i_a_d = d; b0.i_z_r = r;
  endtask

  task automatic drv1(input logic v, input logic [3:0] m, input logic [7:0] d, input logic [3:0] r);
    @(posedge clk); #1;
    b1.i_a_v = v; b1.i_s_v = v; b1.i_s_d = m; b1.i_a_d = d; b1.i_z_r = r;
  endtask

  // Samples the broadcast demux mid-cycle and counts lane handshakes.
  task automatic obs1(input string tag, input logic [3:0] ev, input logic ear, input logic [7:0] d);
    @(negedge clk);
    chk({tag, "_zv"}, 64'(b1.o_z_v), 64'(ev));
    chk({tag, "_ar"}, 64'(b1.o_a_r), 64'(ear));
    chk({tag, "_sr"}, 64'(b1.o_s_r), 64'(ear));
    for (int k = 0; k < 4; k++) begin
      if (b1.o_z_v[k]) begin
        chk({tag, "_zd"}, 64'(b1.o_z_d[k*8 +: 8]), 64'(d));
        if (b1.i_z_r[k]) cnt1[k]++;
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_zv0"}, 64'(b0.o_z_v), 64'(0));
    chk({tag, "_zv1"}, 64'(b1.o_z_v), 64'(0));
    chk({tag, "_zv2"}, 64'(b2.o_z_v), 64'(0));
    chk({tag, "_err"}, 64'({b0.o_err, b1.o_err, b2.o_err}), 64'(0));
    chk({tag, "_ar"},  64'({b0.o_a_r, b1.o_a_r, b2.o_a_r}), 64'(0));
  endtask

  initial begin
    logic [3:0] mask;
    logic [7:0] cur_m, cur_d;
    bit have, err_exp;
    int words;

    b0.i_a_v = 0; b0.i_s_v = 0; b0.i_s_d = '0; b0.i_a_d = '0; b0.i_z_r = '0;
    b1.i_a_v = 0; b1.i_s_v = 0; b1.i_s_d = '0; b1.i_a_d = '0; b1.i_z_r = '0;
    b2.i_a_v = 0; b2.i_s_v = 0; b2.i_s_d = '0; b2.i_a_d = '0; b2.i_z_r = '0;
    for (int k = 0; k < 4; k++) cnt1[k] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Index mode: 0xA1..0xA3 to lanes 0..2 back to back, each one cycle later
    for (int k = 0; k < 4; k++) begin
      drv0(k < 3, 2'(k), 8'hA1 + 8'(k), 3'b111);
      @(negedge clk);
      chk("ix_ar", 64'(b0.o_a_r), 64'(k < 3));
      chk("ix_zv", 64'(b0.o_z_v), (k > 0) ? (64'(1) << (k - 1)) : 64'(0));
      if (k > 0) chk("ix_zd", 64'(b0.o_z_d[(k-1)*8 +: 8]), 64'(8'hA0 + 8'(k)));
    end

    // Index mode: select 3 on a 3-lane demux is dropped and flagged
    drv0(1, 2'd3, 8'h55, 3'b111);
    @(negedge clk);
    chk("inv_ar", 64'(b0.o_a_r), 64'(1));
    chk("inv_zv", 64'(b0.o_z_v), 64'(0));
    chk("inv_err_now", 64'(b0.o_err), 64'(0));
    drv0(0, 2'd0, 8'h00, 3'b111);
    @(negedge clk);
    chk("inv_err_next", 64'(b0.o_err), 64'(1));
    chk("inv_zv_next", 64'(b0.o_z_v), 64'(0));
    drv0(0, 2'd0, 8'h00, 3'b111);
    @(negedge clk);
    chk("inv_err_gone", 64'(b0.o_err), 64'(0));

    // Index mode, Q=1: lane 2 stalled, second word waits for its queue
    drv0(1, 2'd2, 8'hB1, 3'b011);
    @(negedge clk);
    chk("st_ar1", 64'(b0.o_a_r), 64'(1));
    drv0(1, 2'd2, 8'hB2, 3'b011);
    @(negedge clk);
    chk("st_ar2", 64'(b0.o_a_r), 64'(0));
    chk("st_zv2", 64'(b0.o_z_v), 64'(3'b100));
    chk("st_zd2", 64'(b0.o_z_d[16 +: 8]), 64'(8'hB1));
    drv0(1, 2'd2, 8'hB2, 3'b011);
    @(negedge clk);
    chk("st_ar3", 64'(b0.o_a_r), 64'(0));
    drv0(1, 2'd2, 8'hB2, 3'b111);
    @(negedge clk);
    chk("st_ar4", 64'(b0.o_a_r), 64'(0));
    chk("st_zd4", 64'(b0.o_z_d[16 +: 8]), 64'(8'hB1));
    drv0(1, 2'd2, 8'hB2, 3'b111);
    @(negedge clk);
    chk("st_ar5", 64'(b0.o_a_r), 64'(1));
    chk("st_zv5", 64'(b0.o_z_v), 64'(0));
    drv0(0, 2'd0, 8'h00, 3'b111);
    @(negedge clk);
    chk("st_zv6", 64'(b0.o_z_v), 64'(3'b100));
    chk("st_zd6", 64'(b0.o_z_d[16 +: 8]), 64'(8'hB2));
    drv0(0, 2'd0, 8'h00, 3'b111);
    @(negedge clk);
    chk("st_zv7", 64'(b0.o_z_v), 64'(0));

    // Broadcast, Q=0: mask 1011, lane 1 held off for two cycles
    mask = 4'b1011;
    drv1(1, mask, 8'h3C, 4'b1001); obs1("bc1", 4'b1011, 1'b0, 8'h3C);
    drv1(1, mask, 8'h3C, 4'b1001); obs1("bc2", 4'b0010, 1'b0, 8'h3C);
    drv1(1, mask, 8'h3C, 4'b1111); obs1("bc3", 4'b0010, 1'b1, 8'h3C);
    drv1(0, 4'b0000, 8'h00, 4'b1111); obs1("bc4", 4'b0000, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) chk("bc_once", 64'(cnt1[k]), 64'(mask[k]));

    // Broadcast interrupted by reset after lane 0 was delivered
    drv1(1, 4'b0111, 8'h5A, 4'b0001); obs1("rs1", 4'b0111, 1'b0, 8'h5A);
    drv1(1, 4'b0111, 8'h5A, 4'b0000); obs1("rs2", 4'b0110, 1'b0, 8'h5A);
    @(posedge clk); #1;
    reset_n = 1'b0;
    b1.i_a_v = 0; b1.i_s_v = 0;
    #1;
    chk_idle("rs_mid");
    @(posedge clk); #1;
    reset_n = 1'b1;
    drv1(1, 4'b0111, 8'h5A, 4'b1111); obs1("rs3", 4'b0111, 1'b1, 8'h5A);
    drv1(0, 4'b0000, 8'h00, 4'b1111); obs1("rs4", 4'b0000, 1'b0, 8'h00);

    // Random broadcast traffic, M=8, Q=4, random output ready
    have = 0; err_exp = 0; words = 0; cur_m = '0; cur_d = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (!have && cyc < 2500 && $urandom_range(0, 3) != 0) begin
        cur_m = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
        cur_d = 8'($urandom);
        have = 1;
        words++;
        for (int k = 0; k < 8; k++) if (cur_m[k]) expq[k].push_back(cur_d);
      end
      b2.i_a_v = have; b2.i_s_v = have; b2.i_s_d = cur_m; b2.i_a_d = cur_d;
      b2.i_z_r = 8'($urandom);
      @(negedge clk);
      chk("rnd_err", 64'(b2.o_err), 64'(err_exp));
      if (!have) chk("rnd_idle_ar", 64'(b2.o_a_r), 64'(0));
      if (have && cur_m == 8'h00) chk("rnd_inv_ar", 64'(b2.o_a_r), 64'(1));
      for (int k = 0; k < 8; k++) begin
        if (b2.o_z_v[k] && b2.i_z_r[k]) begin
          if (expq[k].size() == 0) chk("rnd_spurious", 64'(b2.o_z_v[k] & b2.i_z_r[k]), 64'(0));
          else chk("rnd_lane_d", 64'(b2.o_z_d[k*8 +: 8]), 64'(expq[k].pop_front()));
        end
      end
      err_exp = have && b2.o_a_r && (cur_m == 8'h00);
      if (have && b2.o_a_r) have = 0;
    end
    b2.i_a_v = 0; b2.i_s_v = 0;
    chk("rnd_stuck", 64'(have), 64'(0));
    for (int k = 0; k < 8; k++) chk("rnd_drain", 64'(expq[k].size()), 64'(0));
    if (words < 100) chk("rnd_words", 64'(words), 64'(100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cory_demuxn.md
# cory_demuxn

Parametrised M-way demultiplexer with per-output buffering and an optional broadcast mode. It routes one valid/ready input stream to any of M output streams, each decoupled by its own `cory_queue`. In index mode a binary select picks one output. In broadcast mode a one-hot/multi-hot mask delivers the same word to several outputs, and partial acceptance is tracked across cycles. Invalid selects are consumed and flagged rather than stalling the pipe. It replaces fixed-count demuxes wherever a stream fans out to engines or lanes.

## Interface
- `N`, default 8: data width.
- `M`, default 4: number of outputs, 2..16.
- `Q`, default 0: depth of every output `cory_queue`; 0 = combinational pass-through.
- `MODE`, default 0: 0 = index select, 1 = broadcast mask.
- `SW`, localparam: select width = M when MODE=1, else max(1, clog2(M)).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_s_v` in 1, `i_s_d` in SW, `o_s_r` out 1: select stream.
- `i_a_v` in 1, `i_a_d` in N, `o_a_r` out 1: data stream.
- `o_z_v` out M, `o_z_d` out M*N, `i_z_r` in M: output streams. Lane k occupies `o_z_d[k*N +: N]`.
- `o_err` out 1: one-cycle pulse, the cycle after an invalid select is dropped.

## Operation
- A transaction exists when `i_a_v && i_s_v`. `o_s_r` and `o_a_r` are always identical; both streams are consumed together.
- Target set T:
  - MODE=0: T = {`i_s_d`} if `i_s_d` < M, else empty.
  - MODE=1: T = bits set in `i_s_d`.
- Empty T means an invalid select. The transaction is consumed in the same cycle (`o_a_r`=1), nothing is written to any queue, and `o_err` is set next cycle.
- Internal `sent[M-1:0]` register, used in MODE=1 only. In MODE=0 it stays 0.
- Lane k internal valid = transaction && T[k] && !sent[k]. Lane data = `i_a_d` for targeted lanes, 0 otherwise.
- Lane k is accepted when its internal valid and its queue's ready are both high.
- Done = every k in T is either `sent[k]` or accepted this cycle. When done, `o_a_r`=1 and `sent` clears to 0.
- When not done, `sent |= accepted lanes`. This prevents duplicate delivery while the remaining lanes stall.
- Sources must hold `i_s_d` and `i_a_d` stable while valid and not ready. A changed select mid-broadcast is a protocol violation; simulation must report it with `$display` ERROR and `$finish` under `SIM`.
- Each output queue obeys `cory_queue` semantics: FIFO order per lane, no reordering.

## Timing
- Reset values: `sent`=0, `o_err`=0, all `o_z_v`=0, and queues empty. `o_a_r`/`o_s_r` are combinational and therefore 0 with no input valid.
- Latency:
  - Q=0: input to `o_z_v` is 0 cycles, and `o_a_r` is combinational from `i_z_r`.
  - Q≥1: one cycle through the queue, and `o_a_r` depends only on queue full state.
- Single-lane accept, broadcast to available lanes: 1 cycle.
- Broadcast with a stalled lane: `o_a_r` rises in the cycle the last pending lane accepts.
- All targeted lanes ready in the same cycle: consumed that cycle, and `sent` never sets.
- Queue full on the target lane: `o_a_r`=0, hold.
- Back-to-back transactions at full throughput are supported when queues are not full.
- Async reset mid-broadcast clears `sent` and the queues immediately. The partially delivered word is lost and is not redelivered.
- `o_err` never stays high 2 consecutive cycles unless invalid selects are consumed on consecutive cycles.

## Structure
- Shared defines header holds `CORY_DEMUX_IDX`=0 and `CORY_DEMUX_BCAST`=1, used for `MODE`.
- Sub-module: `cory_queue`, one instance per lane via a generate loop.
- Under `SIM` + `CORY_MON`: one `cory_monitor` per lane.

## Test plan
- MODE=0, M=4, Q=2, all `i_z_r`=1. Send 0xA1..0xA4 with select 0,1,2,3 → each lane receives exactly its word, one cycle after acceptance.
- MODE=0, M=3, select=3, data=0x55 → consumed the same cycle, `o_err`=1 the next cycle only, no `o_z_v`.
- MODE=1, M=4, Q=0, mask 0b1011, data 0x3C, `i_z_r`=0b1001 for 2 cycles then 0b1111:
  - lanes 0 and 3 see 0x3C once;
  - lane 1 sees 0x3C on cycle 3;
  - `o_a_r` rises on cycle 3, with no duplicates.
- MODE=0, Q=1, lane 2 `i_z_r`=0, two words to lane 2 → second word stalls with `o_a_r`=0 until `i_z_r`[2] rises.
- Assert `reset_n`=0 mid-broadcast with `sent`=0b0001 → all `o_z_v`=0 and `sent`=0. After release, the same mask delivers to all targeted lanes.
- Random stress, M=8, Q=4, MODE=1, random ready → the scoreboard sees per-lane order preserved and every word delivered exactly once per mask bit.
